// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one main-memory port between the I-cache refill path
// and the D-cache refill/write-back path. One request is latched at a time and
// held on the memory port until memory completes it. The completion is routed
// back to the cache that owns the request. When both caches are waiting, round-robin
// arbitration lets one master keep the port for at most HOLD_LIMIT consecutive grants.
module memory_arbiter #(
    parameter int HOLD_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        icache_mem_req,
    input  logic [31:0] icache_mem_addr,
    output logic [31:0] icache_mem_rdata,
    output logic        icache_mem_ready,

    input  logic        dcache_mem_req,
    input  logic [31:0] dcache_mem_addr,
    input  logic [31:0] dcache_mem_wdata,
    input  logic [3:0]  dcache_mem_be,
    input  logic        dcache_mem_we,
    output logic [31:0] dcache_mem_rdata,
    output logic        dcache_mem_ready,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic [31:0] icache_grant_count,
    output logic [31:0] dcache_grant_count
);

    // Streak only needs to count up to HOLD_LIMIT; it saturates there.
    localparam int                     STREAK_W   = $clog2(HOLD_LIMIT + 1);
    localparam logic [STREAK_W-1:0]    STREAK_MAX = STREAK_W'(HOLD_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic                mem_we_q, mem_we_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                last_owner_i_q, last_owner_i_d;   // 1 = I-cache, 0 = D-cache
    logic [31:0]         icount_q, icount_d;
    logic [31:0]         dcount_q, dcount_d;

    logic                grant_i;
    logic                grant_d;
    logic                keep_owner;
    logic                same_owner;

    // State and latched memory-port registers; reset is immediate and abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            mem_be_q       <= 4'd0;
            mem_we_q       <= 1'b0;
            streak_q       <= '0;
            last_owner_i_q <= 1'b0;
            icount_q       <= 32'd0;
            dcount_q       <= 32'd0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
            mem_we_q       <= mem_we_d;
            streak_q       <= streak_d;
            last_owner_i_q <= last_owner_i_d;
            icount_q       <= icount_d;
            dcount_q       <= dcount_d;
        end
    end

    // Arbitration, latching, completion routing and next-state selection.
    always_comb begin
        state_d          = state_q;
        mem_req_d        = mem_req_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        mem_be_d         = mem_be_q;
        mem_we_d         = mem_we_q;
        streak_d         = streak_q;
        last_owner_i_d   = last_owner_i_q;
        icount_d         = icount_q;
        dcount_d         = dcount_q;
        grant_i          = 1'b0;
        grant_d          = 1'b0;
        keep_owner       = 1'b0;
        same_owner       = 1'b0;
        icache_mem_ready = 1'b0;
        icache_mem_rdata = 32'd0;
        dcache_mem_ready = 1'b0;
        dcache_mem_rdata = 32'd0;

        case (state_q)
            IDLE: begin
                if (icache_mem_req && dcache_mem_req) begin
                    // A zero streak means nobody holds the port yet (only after
                    // reset), so the tie goes away from last_owner, i.e. to the I-cache.
                    keep_owner = (streak_q != '0) && (streak_q < STREAK_MAX);
                    grant_i    = keep_owner ? last_owner_i_q : !last_owner_i_q;
                    grant_d    = !grant_i;
                end else begin
                    grant_i = icache_mem_req;
                    grant_d = dcache_mem_req;
                end

                if (grant_i) begin
                    mem_addr_d  = icache_mem_addr;
                    mem_wdata_d = 32'd0;
                    mem_be_d    = 4'hF;
                    mem_we_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    state_d     = BUSY_I;
                end else if (grant_d) begin
                    mem_addr_d  = dcache_mem_addr;
                    mem_wdata_d = dcache_mem_wdata;
                    mem_be_d    = dcache_mem_be;
                    mem_we_d    = dcache_mem_we;
                    mem_req_d   = 1'b1;
                    state_d     = BUSY_D;
                end

                if (grant_i || grant_d) begin
                    same_owner = (grant_i == last_owner_i_q);
                    if (same_owner) begin
                        if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end else begin
                        streak_d       = STREAK_W'(1);
                        last_owner_i_d = grant_i;
                    end
                end
            end

            BUSY_I: begin
                if (mem_ready) begin
                    icache_mem_ready = 1'b1;
                    icache_mem_rdata = mem_rdata;
                    icount_d         = icount_q + 32'd1;
                    mem_req_d        = 1'b0;
                    state_d          = IDLE;
                end
            end

            BUSY_D: begin
                if (mem_ready) begin
                    dcache_mem_ready = 1'b1;
                    dcache_mem_rdata = mem_rdata;
                    dcount_d         = dcount_q + 32'd1;
                    mem_req_d        = 1'b0;
                    state_d          = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign mem_req            = mem_req_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign mem_be             = mem_be_q;
    assign mem_we             = mem_we_q;
    assign icache_grant_count = icount_q;
    assign dcache_grant_count = dcount_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: the stimulus process drives both caches and a
// memory model, and pushes expected grants/completions into queues from a
// transaction-level reference model; a negedge monitor pops and compares.
module tb_memory_arbiter;

    localparam int HOLD = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_we;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] i_cnt_o;
    logic [31:0] d_cnt_o;

    memory_arbiter #(.HOLD_LIMIT(HOLD)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .icache_mem_req     (i_req),
        .icache_mem_addr    (i_addr),
        .icache_mem_rdata   (i_rdata),
        .icache_mem_ready   (i_ready),
        .dcache_mem_req     (d_req),
        .dcache_mem_addr    (d_addr),
        .dcache_mem_wdata   (d_wdata),
        .dcache_mem_be      (d_be),
        .dcache_mem_we      (d_we),
        .dcache_mem_rdata   (d_rdata),
        .dcache_mem_ready   (d_ready),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_be             (mem_be),
        .mem_we             (mem_we),
        .mem_rdata          (mem_rdata),
        .mem_ready          (mem_ready),
        .icache_grant_count (i_cnt_o),
        .dcache_grant_count (d_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } grant_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        logic [31:0] cnt;
    } done_t;

    grant_t      gq[$];
    done_t       cq[$];
    bit          hist[$];          // past winners, 1 = D-cache

    int          checks = 0;
    int          errors = 0;
    bit          busy = 0;
    bit          owner_d = 0;
    bit          done_now = 0;
    bit          count_check = 0;
    int          lat = 0;
    logic [31:0] icnt = 0;
    logic [31:0] dcnt = 0;

    // stimulus knobs
    int          new_pct = 0;
    int          keep_pct = 0;
    int          fixed_lat = -1;
    int          spur_pct = 0;
    int          drop_pct = 0;
    bit          scramble = 0;
    bit          use_fixed_rdata = 0;
    logic [31:0] fixed_rdata = 0;

    // Round-robin with bounded streak, expressed over the list of past winners.
    function automatic bit pick_d(bit ir, bit dr);
        int run;
        bit last;
        if (ir && !dr) return 1'b0;
        if (dr && !ir) return 1'b1;
        if (hist.size() == 0) return 1'b0;
        last = hist[hist.size() - 1];
        run  = 0;
        for (int k = hist.size() - 1; k >= 0 && run < HOLD; k--) begin
            if (hist[k] == last) run++;
            else break;
        end
        return (run < HOLD) ? last : !last;
    endfunction

    // One clock of stimulus: apply the previous edge to the model, drive memory, then the caches.
    task automatic step();
        grant_t g;
        done_t  c;
        bit     w;
        @(posedge clk);
        #1;
        done_now = 0;
        if (rst_n) begin
            if (busy) begin
                if (mem_ready) busy = 0;
            end else if (i_req || d_req) begin
                w      = pick_d(i_req, d_req);
                g.is_d = w;
                g.addr  = w ? d_addr  : i_addr;
                g.wdata = w ? d_wdata : 32'd0;
                g.be    = w ? d_be    : 4'hF;
                g.we    = w ? d_we    : 1'b0;
                gq.push_back(g);
                hist.push_back(w);
                busy    = 1;
                owner_d = w;
                lat     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            end
        end

        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (busy) begin
            if (lat == 0) begin
                mem_ready = 1'b1;
                if (use_fixed_rdata) mem_rdata = fixed_rdata;
                c.is_d  = owner_d;
                c.rdata = mem_rdata;
                c.cnt   = owner_d ? dcnt : icnt;
                cq.push_back(c);
                if (owner_d) dcnt = dcnt + 1;
                else         icnt = icnt + 1;
                done_now = 1;
            end else begin
                lat--;
            end
        end else if (int'($urandom_range(0, 99)) < spur_pct) begin
            mem_ready = 1'b1;
        end

        // I-cache master
        if (done_now && !owner_d) begin
            if (int'($urandom_range(0, 99)) < keep_pct) i_addr = $urandom;
            else i_req = 1'b0;
        end else if (!i_req && int'($urandom_range(0, 99)) < new_pct) begin
            i_req  = 1'b1;
            i_addr = $urandom;
        end

        // D-cache master
        if (done_now && owner_d) begin
            if (int'($urandom_range(0, 99)) < keep_pct) begin
                d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
            end else begin
                d_req = 1'b0;
            end
        end else if (busy && owner_d) begin
            if (scramble) begin
                d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
            end
            if (int'($urandom_range(0, 99)) < drop_pct) d_req = 1'b0;
        end else if (!d_req && int'($urandom_range(0, 99)) < new_pct) begin
            d_req = 1'b1;
            d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
        end
    endtask

    // Asynchronous reset between edges, leaving both caches requesting on release.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        gq.delete();
        cq.delete();
        hist.delete();
        busy = 0; icnt = 0; dcnt = 0; lat = 0;
        mem_ready = 1'b0;
        i_req = 1'b1; i_addr = $urandom;
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    grant_t cur;
    done_t  cd;
    bit     cur_valid = 0;

    // Monitor: compares DUT outputs against queued expectations away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_valid = 0;
            chk("rst_mem_req",   32'(mem_req),   32'd0);
            chk("rst_mem_addr",  mem_addr,       32'd0);
            chk("rst_mem_wdata", mem_wdata,      32'd0);
            chk("rst_mem_be",    32'(mem_be),    32'd0);
            chk("rst_mem_we",    32'(mem_we),    32'd0);
            chk("rst_i_ready",   32'(i_ready),   32'd0);
            chk("rst_d_ready",   32'(d_ready),   32'd0);
            chk("rst_i_rdata",   i_rdata,        32'd0);
            chk("rst_d_rdata",   d_rdata,        32'd0);
            chk("rst_i_count",   i_cnt_o,        32'd0);
            chk("rst_d_count",   d_cnt_o,        32'd0);
        end else begin
            chk("mem_req_busy", 32'(mem_req), 32'(busy));
            if (gq.size() > 0) begin
                cur = gq.pop_front();
                cur_valid = 1;
                chk("grant_addr",  mem_addr,     cur.addr);
                chk("grant_wdata", mem_wdata,    cur.wdata);
                chk("grant_be",    32'(mem_be),  32'(cur.be));
                chk("grant_we",    32'(mem_we),  32'(cur.we));
            end else if (mem_req && cur_valid) begin
                chk("hold_addr",  mem_addr,     cur.addr);
                chk("hold_wdata", mem_wdata,    cur.wdata);
                chk("hold_be",    32'(mem_be),  32'(cur.be));
                chk("hold_we",    32'(mem_we),  32'(cur.we));
            end
            if (cq.size() > 0) begin
                cd = cq.pop_front();
                $display("done %s rdata=%h count=%0d", cd.is_d ? "D" : "I", cd.rdata, cd.cnt);
                chk("done_i_ready", 32'(i_ready), cd.is_d ? 32'd0 : 32'd1);
                chk("done_d_ready", 32'(d_ready), cd.is_d ? 32'd1 : 32'd0);
                chk("done_i_rdata", i_rdata,      cd.is_d ? 32'd0 : cd.rdata);
                chk("done_d_rdata", d_rdata,      cd.is_d ? cd.rdata : 32'd0);
                if (cd.is_d) chk("done_d_count", d_cnt_o, cd.cnt);
                else         chk("done_i_count", i_cnt_o, cd.cnt);
            end else begin
                chk("idle_i_ready", 32'(i_ready), 32'd0);
                chk("idle_d_ready", 32'(d_ready), 32'd0);
                chk("idle_i_rdata", i_rdata,      32'd0);
                chk("idle_d_rdata", d_rdata,      32'd0);
            end
            if (count_check) begin
                chk("final_i_count", i_cnt_o, icnt);
                chk("final_d_count", d_cnt_o, dcnt);
            end
        end
    end

    bit did_reset = 0;

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0; d_we = 1'b0;
        mem_rdata = 32'd0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single I-cache read of 0x100, 3-cycle memory, fixed read data
        i_req = 1'b1; i_addr = 32'h100;
        fixed_lat = 3; use_fixed_rdata = 1; fixed_rdata = 32'hDEADBEEF;
        repeat (10) step();

        // D-cache write with a long stall while its pins keep changing
        use_fixed_rdata = 0; fixed_lat = 5; scramble = 1;
        d_req = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011; d_we = 1'b1;
        repeat (12) step();

        // both caches requesting continuously with single-cycle memory
        scramble = 0; fixed_lat = 0; new_pct = 100; keep_pct = 100;
        i_req = 1'b1; i_addr = $urandom;
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
        repeat (40) step();

        // randomized traffic with stray mem_ready, pin churn and one reset during a D transaction
        fixed_lat = -1; new_pct = 40; keep_pct = 50; spur_pct = 15; scramble = 1; drop_pct = 10;
        for (int n = 0; n < 600; n++) begin
            step();
            if (!did_reset && n > 300 && busy && owner_d && !done_now) begin
                do_reset();
                did_reset = 1;
            end
        end

        // drain and compare totals
        new_pct = 0; keep_pct = 0;
        repeat (30) step();
        count_check = 1;
        @(negedge clk);
        #1;
        count_check = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
